// File: rtl/nvm_burst_ctrl.sv
// Burst controller for the ReRAM NVM port: one command moves len_m1+1 words between the NVM and
// the rd/wr valid/ready streams, with a per-access ack timeout that aborts the burst.
module nvm_burst_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len_m1,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  nvm_we,
  output logic [ADDR_WIDTH-1:0] nvm_addr,
  output logic [DATA_WIDTH-1:0] nvm_wdata,
  input  logic [DATA_WIDTH-1:0] nvm_rdata,
  input  logic                  nvm_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StPush, StFetch, StWissue, StDone
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [TmoWidth-1:0]   tmo_q;
  logic                  dir_q;
  logic                  last;

  assign last = (cnt_q == len_q);

  // Handshake and strobe outputs are pure decodes of the state register.
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign rd_valid  = (state_q == StPush);
  assign wr_ready  = (state_q == StFetch);
  assign nvm_we    = (state_q == StWissue);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      dir_q     <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      nvm_addr  <= '0;
      nvm_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cur_q <= cmd_addr;
            len_q <= cmd_len_m1;
            dir_q <= cmd_write;
            cnt_q <= '0;
            tmo_q <= '0;
            err   <= 1'b0;
            if (cmd_write) begin
              state_q <= StFetch;
            end else begin
              nvm_addr <= cmd_addr;
              state_q  <= StIssue;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (nvm_ack) begin
            tmo_q <= '0;
            if (!dir_q) begin
              rd_data <= nvm_rdata;
              state_q <= StPush;
            end else if (last) begin
              state_q <= StDone;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              cur_q   <= cur_q + 1'b1;
              state_q <= StFetch;
            end
          end else if (tmo_q == TmoWidth'(TIMEOUT - 1)) begin
            // Abandon the rest of the burst; err stays set until the next command.
            tmo_q   <= '0;
            err     <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StPush: begin
          if (rd_ready) begin
            if (last) begin
              state_q <= StDone;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              cur_q    <= cur_q + 1'b1;
              nvm_addr <= cur_q + 1'b1;
              state_q  <= StIssue;
            end
          end
        end
        StFetch: begin
          if (wr_valid) begin
            nvm_wdata <= wr_data;
            nvm_addr  <= cur_q;
            state_q   <= StWissue;
          end
        end
        StWissue: state_q <= StWait;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_burst_ctrl.sv
// Scoreboard bench for nvm_burst_ctrl: a behavioural NVM model plus directed bursts; a monitor
// pops expected read words and NVM writes from queues as the DUT presents them.
module tb_nvm_burst_ctrl;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_len_m1 = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       nvm_we;
  logic [7:0] nvm_addr;
  logic [7:0] nvm_wdata;
  logic [7:0] nvm_rdata;
  logic       nvm_ack;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] mem [256];
  logic       nvm_hold = 1'b0;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0;
  logic [7:0] bd_data = '0;

  xfer_t      rd_q[$];
  xfer_t      wr_q[$];
  logic [7:0] wdat [4];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  bit chk_gap = 1'b0;
  bit have_last = 1'b0;

  nvm_burst_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .TIMEOUT   (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len_m1(cmd_len_m1),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .nvm_we    (nvm_we),
    .nvm_addr  (nvm_addr),
    .nvm_wdata (nvm_wdata),
    .nvm_rdata (nvm_rdata),
    .nvm_ack   (nvm_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // NVM model: one access per clock, registered read data, ack suppressed while held.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (nvm_we) mem[nvm_addr] <= nvm_wdata;
    nvm_rdata <= mem[nvm_addr];
    nvm_ack   <= !nvm_hold;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin
    xfer_t      e;
    bit         prev_stall;
    logic [7:0] prev_data;
    int         last_hs;
    prev_stall = 1'b0;
    prev_data  = '0;
    last_hs    = 0;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          e = rd_q.pop_front();
          check("rd_addr", nvm_addr, e.a);
          check("rd_data", rd_data, e.d);
        end
        if (chk_gap && have_last) check("rd_gap", cyc - last_hs, 3);
        have_last = 1'b1;
        last_hs   = cyc;
      end
      if (prev_stall && rd_valid) check("rd_hold", rd_data, prev_data);
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (nvm_we) begin
        we_cnt++;
        if (wr_q.size() == 0) begin
          check("we_unexpected", 1, 0);
        end else begin
          e = wr_q.pop_front();
          check("we_addr", nvm_addr, e.a);
          check("we_data", nvm_wdata, e.d);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    int k;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_len_m1 = l;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 200);
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_writes(input int n, input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data = wdat[i];
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!wr_ready && k < 200);
      if (!wr_ready) check("wr_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
    end
  endtask

  // Returns cycles from the one after acceptance (n=1) to the done cycle.
  task automatic wait_done(output int n, input bit toggle);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done || n >= 300) break;
      @(posedge clk);
      #1;
      if (toggle) rd_ready = ~rd_ready;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_busy", busy, 1);
      check("done_cmd_ready", cmd_ready, 0);
      @(negedge clk);
      check("post_done_pulse", done, 0);
      check("post_done_cmd_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    int n;
    int we0;
    int d0;
    preload(8'h10, 8'hA1);
    preload(8'h11, 8'hB2);
    preload(8'h12, 8'hC3);
    preload(8'h13, 8'hD4);
    preload(8'hFE, 8'h5A);
    preload(8'hFF, 8'h6B);
    preload(8'h00, 8'h7C);
    preload(8'h01, 8'h8D);
    preload(8'h32, 8'hEE);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_nvm_we", nvm_we, 0);
    check("rst_nvm_addr", nvm_addr, 0);
    check("rst_nvm_wdata", nvm_wdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Restore burst at full rate: one word every 3 cycles.
    rd_ready = 1'b1;
    rd_q.push_back('{8'h10, 8'hA1});
    rd_q.push_back('{8'h11, 8'hB2});
    rd_q.push_back('{8'h12, 8'hC3});
    rd_q.push_back('{8'h13, 8'hD4});
    have_last = 1'b0;
    chk_gap = 1'b1;
    send_cmd(1'b0, 8'h10, 8'd3);
    wait_done(n, 1'b0);
    chk_gap = 1'b0;
    @(negedge clk);
    check("t1_err", err, 0);
    check("t1_done_cnt", done_cnt, 1);

    // Store burst with 2-cycle gaps on wr_valid, then read it back.
    we0 = we_cnt;
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    wdat[2] = 8'h33;
    wr_q.push_back('{8'h20, 8'h11});
    wr_q.push_back('{8'h21, 8'h22});
    wr_q.push_back('{8'h22, 8'h33});
    send_cmd(1'b1, 8'h20, 8'd2);
    drive_writes(3, 2);
    wait_done(n, 1'b0);
    check("t2_we_count", we_cnt - we0, 3);
    rd_q.push_back('{8'h20, 8'h11});
    rd_q.push_back('{8'h21, 8'h22});
    rd_q.push_back('{8'h22, 8'h33});
    send_cmd(1'b0, 8'h20, 8'd2);
    wait_done(n, 1'b0);

    // Wrapping read with rd_ready toggling every cycle.
    rd_ready = 1'b0;
    rd_q.push_back('{8'hFE, 8'h5A});
    rd_q.push_back('{8'hFF, 8'h6B});
    rd_q.push_back('{8'h00, 8'h7C});
    rd_q.push_back('{8'h01, 8'h8D});
    send_cmd(1'b0, 8'hFE, 8'd3);
    wait_done(n, 1'b1);
    rd_ready = 1'b1;

    // Timeout: NVM never acks, so 15 WAIT cycles then DONE at n=17.
    nvm_hold = 1'b1;
    d0 = done_cnt;
    send_cmd(1'b0, 8'h10, 8'd3);
    wait_done(n, 1'b0);
    check("t4_timeout_cycles", n, 17);
    check("t4_err_set", err, 1);
    check("t4_done_cnt", done_cnt - d0, 1);
    nvm_hold = 1'b0;
    rd_q.push_back('{8'h10, 8'hA1});
    send_cmd(1'b0, 8'h10, 8'd0);
    @(negedge clk);
    check("t4_err_cleared", err, 0);
    wait_done(n, 1'b0);

    // Reset after 2 of 4 written words.
    we0 = we_cnt;
    d0 = done_cnt;
    wdat[0] = 8'h01;
    wdat[1] = 8'h02;
    wdat[2] = 8'h03;
    wdat[3] = 8'h04;
    wr_q.push_back('{8'h30, 8'h01});
    wr_q.push_back('{8'h31, 8'h02});
    send_cmd(1'b1, 8'h30, 8'd3);
    drive_writes(2, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_nvm_we", nvm_we, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_wr_ready", wr_ready, 0);
    check("t5_nvm_addr", nvm_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_we_count", we_cnt - we0, 2);
    check("t5_no_done", done_cnt, d0);
    check("t5_mem30", mem[8'h30], 8'h01);
    check("t5_mem31", mem[8'h31], 8'h02);
    check("t5_mem32", mem[8'h32], 8'hEE);
    wdat[0] = 8'h99;
    wr_q.push_back('{8'h40, 8'h99});
    send_cmd(1'b1, 8'h40, 8'd0);
    drive_writes(1, 1);
    wait_done(n, 1'b0);
    check("t5_mem40", mem[8'h40], 8'h99);

    // Command pulsed mid-burst must be ignored.
    we0 = we_cnt;
    d0 = done_cnt;
    rd_q.push_back('{8'h10, 8'hA1});
    rd_q.push_back('{8'h11, 8'hB2});
    rd_q.push_back('{8'h12, 8'hC3});
    rd_q.push_back('{8'h13, 8'hD4});
    send_cmd(1'b0, 8'h10, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h80;
    cmd_len_m1 = 8'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(n, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_idle", busy, 0);
    check("t6_no_writes", we_cnt, we0);
    check("t6_done_cnt", done_cnt - d0, 1);

    check("rd_queue_empty", rd_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
